// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: request op codes,
// MIPS opcode/funct values, loader FSM states and the word encode helpers.
package isa_pkg;

  // Symbolic instruction requests; codes 27..31 are illegal.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_SLL  = 5'd4,  OP_SRL  = 5'd5,  OP_JR   = 5'd6,  OP_MUL  = 5'd7,
    OP_ADDI = 5'd8,  OP_ANDI = 5'd9,  OP_ORI  = 5'd10, OP_XORI = 5'd11,
    OP_SLTI = 5'd12, OP_LW   = 5'd13, OP_SW   = 5'd14, OP_LB   = 5'd15,
    OP_LH   = 5'd16, OP_SB   = 5'd17, OP_SH   = 5'd18, OP_BEQ  = 5'd19,
    OP_BNE  = 5'd20, OP_BLEZ = 5'd21, OP_BGTZ = 5'd22, OP_BGEZ = 5'd23,
    OP_BLTZ = 5'd24, OP_J    = 5'd25, OP_JAL  = 5'd26
  } op_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_MUL    = 6'b011100;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_XORI   = 6'b001110;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;
  localparam logic [5:0] OPC_LB     = 6'b100000;
  localparam logic [5:0] OPC_LH     = 6'b100001;
  localparam logic [5:0] OPC_SB     = 6'b101000;
  localparam logic [5:0] OPC_SH     = 6'b101001;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b000010;

  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] RT_BLTZ = 5'b00000;

  // Control-transfer requests; these get a delay-slot NOP when that is enabled.
  function automatic logic is_ctrl(input logic [4:0] op);
    case (op)
      OP_JR, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_BGEZ, OP_BLTZ, OP_J, OP_JAL: is_ctrl = 1'b1;
      default:                         is_ctrl = 1'b0;
    endcase
  endfunction

  // Returns {legal, word}; fields an instruction does not use are zeroed.
  function automatic logic [32:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [32:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   res = {1'b1, OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      OP_SLL:  res = {1'b1, OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      OP_SRL:  res = {1'b1, OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      OP_JR:   res = {1'b1, OPC_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
      OP_MUL:  res = {1'b1, OPC_MUL, rs, rt, rd, 5'd0, FN_MUL};
      OP_ADDI: res = {1'b1, OPC_ADDI, rs, rt, imm};
      OP_ANDI: res = {1'b1, OPC_ANDI, rs, rt, imm};
      OP_ORI:  res = {1'b1, OPC_ORI, rs, rt, imm};
      OP_XORI: res = {1'b1, OPC_XORI, rs, rt, imm};
      OP_SLTI: res = {1'b1, OPC_SLTI, rs, rt, imm};
      OP_LW:   res = {1'b1, OPC_LW, rs, rt, imm};
      OP_SW:   res = {1'b1, OPC_SW, rs, rt, imm};
      OP_LB:   res = {1'b1, OPC_LB, rs, rt, imm};
      OP_LH:   res = {1'b1, OPC_LH, rs, rt, imm};
      OP_SB:   res = {1'b1, OPC_SB, rs, rt, imm};
      OP_SH:   res = {1'b1, OPC_SH, rs, rt, imm};
      OP_BEQ:  res = {1'b1, OPC_BEQ, rs, rt, imm};
      OP_BNE:  res = {1'b1, OPC_BNE, rs, rt, imm};
      OP_BLEZ: res = {1'b1, OPC_BLEZ, rs, 5'd0, imm};
      OP_BGTZ: res = {1'b1, OPC_BGTZ, rs, 5'd0, imm};
      OP_BGEZ: res = {1'b1, OPC_REGIMM, rs, RT_BGEZ, imm};
      OP_BLTZ: res = {1'b1, OPC_REGIMM, rs, RT_BLTZ, imm};
      OP_J:    res = {1'b1, OPC_J, target};
      OP_JAL:  res = {1'b1, OPC_JAL, target};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head is read combinationally so
// the loader can present it directly as write data. Flush empties it at once.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards everything stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes symbolic instruction requests into MIPS words, buffers them and
// streams them into instruction memory. Optional build macro:
// DELAY_SLOT_NOP_EN - append a NOP word after every branch/jump.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Finish,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  OpSel,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [25:0] Target,
  output logic        MemWrite,
  input  logic        MemReady,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        Error,
  output logic        Done,
  output logic [15:0] Count
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [32:0]   enc;
  logic          accept;
  logic          fifo_push;
  logic [31:0]   fifo_push_data;
  logic          fifo_pop;
  logic [31:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          drain_idle;

  assign enc    = encode(OpSel, Rs, Rt, Rd, Shamt, Imm, Target);
  // A Start in the same cycle flushes, so the request is dropped with it.
  assign accept = InValid && InReady && !Start;

`ifdef DELAY_SLOT_NOP_EN
  logic nop_pending;
  logic ctrl_req;
  logic room_two;

  assign ctrl_req       = is_ctrl(OpSel);
  assign room_two       = (fifo_count <= CW'(DEPTH - 2));
  assign InReady        = (state == ST_LOAD) && !nop_pending &&
                          (ctrl_req ? room_two : !fifo_full);
  assign fifo_push      = (accept && enc[32]) || nop_pending;
  assign fifo_push_data = nop_pending ? 32'h0 : enc[31:0];
  assign drain_idle     = (fifo_count == '0) && !nop_pending;

  // The NOP goes in the cycle after its branch; room was reserved at accept.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        nop_pending <= 1'b0;
    else if (Start) nop_pending <= 1'b0;
    else            nop_pending <= accept && ctrl_req;
  end
`else
  assign InReady        = (state == ST_LOAD) && !fifo_full;
  assign fifo_push      = accept && enc[32];
  assign fifo_push_data = enc[31:0];
  assign drain_idle     = (fifo_count == '0);
`endif

  assign fifo_pop     = !fifo_empty && MemReady;
  assign MemWrite     = !fifo_empty;
  assign MemWriteData = fifo_empty ? 32'h0 : fifo_head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .flush     (Start),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Loader FSM plus address/count/error bookkeeping; Start overrides all.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      MemAddress <= BASE_ADDR;
      Count      <= 16'd0;
      Error      <= 1'b0;
      Done       <= 1'b0;
    end else if (Start) begin
      state      <= ST_LOAD;
      MemAddress <= BASE_ADDR;
      Count      <= 16'd0;
      Error      <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_LOAD:  if (Finish) state <= ST_DRAIN;
        ST_DRAIN: if (drain_idle) begin
          state <= ST_DONE;
          Done  <= 1'b1;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (accept && !enc[32]) Error <= 1'b1;
      if (fifo_pop) begin
        MemAddress <= MemAddress + 32'd4;
        if (Count != 16'hFFFF) Count <= Count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: reset, encodings, backpressure,
// illegal requests, drain/Done and optional delay-slot NOPs.
module tb_instr_encode_loader;
  import isa_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        Clk, Rst, Start, Finish, InValid, InReady;
  logic [4:0]  OpSel, Rs, Rt, Rd, Shamt;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        MemWrite, MemReady, Error, Done;
  logic [31:0] MemAddress, MemWriteData;
  logic [15:0] Count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_count;

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    bit          ctrl;
  } vec_t;
  vec_t vecs[8];

  instr_encode_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Finish(Finish),
    .InValid(InValid), .InReady(InReady), .OpSel(OpSel),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Target(Target),
    .MemWrite(MemWrite), .MemReady(MemReady), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .Error(Error), .Done(Done), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    exp_addr  = BASE;
    exp_count = 16'd0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    int waited;
    waited = 0;
    OpSel = op; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tgt;
    InValid = 1'b1;
    while (!InReady && waited < 50) begin
      tick();
      waited++;
    end
    check("send_ready", {31'd0, InReady}, 32'd1);
    tick();
    InValid = 1'b0;
    $display("send op=%0d rs=%0d rt=%0d rd=%0d sh=%0d imm=%h tgt=%h", op, rs, rt, rd, sh, imm, tgt);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] data);
    int waited;
    waited = 0;
    while (!MemWrite && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_wr"}, {31'd0, MemWrite}, 32'd1);
    check({tag, "_addr"}, MemAddress, exp_addr);
    check({tag, "_data"}, MemWriteData, data);
    $display("write %s addr=%h data=%h", tag, MemAddress, MemWriteData);
    MemReady = 1'b1;
    tick();
    MemReady = 1'b0;
    exp_addr  = exp_addr + 32'd4;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic pop_ctrl(input string tag, input logic [31:0] data);
    pop_check(tag, data);
`ifdef DELAY_SLOT_NOP_EN
    pop_check({tag, "_nop"}, 32'h0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inready"}, {31'd0, InReady}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    check({tag, "_addr"}, MemAddress, BASE);
    check({tag, "_wdata"}, MemWriteData, 32'h0);
    check({tag, "_error"}, {31'd0, Error}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_count"}, {16'd0, Count}, 32'd0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{OP_SUB,  5'd1,  5'd2,  5'd3, 5'd5, 16'h0,    26'h0,       32'h00221822, 1'b0};
    vecs[1] = '{OP_SLL,  5'd7,  5'd2,  5'd3, 5'd4, 16'h0,    26'h0,       32'h00021900, 1'b0};
    vecs[2] = '{OP_JR,   5'd31, 5'd5,  5'd6, 5'd7, 16'h0,    26'h0,       32'h03E00008, 1'b1};
    vecs[3] = '{OP_MUL,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0,       32'h70221802, 1'b0};
    vecs[4] = '{OP_SW,   5'd29, 5'd31, 5'd4, 5'd0, 16'hFFFC, 26'h0,       32'hAFBFFFFC, 1'b0};
    vecs[5] = '{OP_BLEZ, 5'd5,  5'd9,  5'd0, 5'd0, 16'h0007, 26'h0,       32'h18A00007, 1'b1};
    vecs[6] = '{OP_J,    5'd1,  5'd0,  5'd0, 5'd0, 16'h0,    26'h3FFFFFF, 32'h0BFFFFFF, 1'b1};
    vecs[7] = '{OP_ORI,  5'd3,  5'd4,  5'd0, 5'd0, 16'h1234, 26'h0,       32'h34641234, 1'b0};

    Rst = 1'b1; Start = 1'b0; Finish = 1'b0; InValid = 1'b0; MemReady = 1'b0;
    OpSel = 5'd0; Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; Shamt = 5'd0; Imm = 16'h0; Target = 26'h0;
    exp_addr = BASE; exp_count = 16'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_values("por");
    Rst = 1'b0;
    tick();
    check("idle_inready", {31'd0, InReady}, 32'd0);

    // Load four words, write one, then reset with three still queued.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'(i), 26'h0);
    pop_check("pre_rst", 32'h20080000);
    check("pre_rst_count", {16'd0, Count}, 32'd1);
    check("pre_rst_pending", {31'd0, MemWrite}, 32'd1);
    #2 Rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    tick();
    Rst = 1'b0;
    tick();
    check("post_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("post_rst_inready", {31'd0, InReady}, 32'd0);

    // Basic encodings and write stream.
    pulse_start();
    check("start_inready", {31'd0, InReady}, 32'd1);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    pop_check("add", 32'h00221820);
    send(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    pop_check("addi", 32'h20080005);
    check("count2", {16'd0, Count}, 32'd2);
    send(OP_BGEZ, 5'd4, 5'd9, 5'd0, 5'd0, 16'h0003, 26'h0);
    pop_ctrl("bgez", 32'h04810003);
    send(OP_BLTZ, 5'd4, 5'd7, 5'd0, 5'd0, 16'h0003, 26'h0);
    pop_ctrl("bltz", 32'h04800003);
    send(OP_JAL, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    pop_ctrl("jal", 32'h0C000010);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      if (vecs[i].ctrl) pop_ctrl($sformatf("vec%0d", i), vecs[i].exp);
      else pop_check($sformatf("vec%0d", i), vecs[i].exp);
    end
    check("stream_count", {16'd0, Count}, {16'd0, exp_count});
    check("stream_addr", MemAddress, exp_addr);

    // Backpressure: fill the FIFO, then release and check order.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0100 + 16'(i), 26'h0);
    check("full_inready", {31'd0, InReady}, 32'd0);
    check("full_memwrite", {31'd0, MemWrite}, 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("bp%0d", i), 32'h20080100 + 32'(i));
    check("bp_count", {16'd0, Count}, DEPTH);
    check("bp_empty", {31'd0, MemWrite}, 32'd0);

    // Illegal request: accepted, nothing written, Error sticky.
    send(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h0);
    tick();
    check("illegal_error", {31'd0, Error}, 32'd1);
    check("illegal_nowrite", {31'd0, MemWrite}, 32'd0);
    check("illegal_count", {16'd0, Count}, {16'd0, exp_count});

    // Finish with one word queued: Done only after it is written.
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    check("drain_inready", {31'd0, InReady}, 32'd0);
    check("drain_done_early", {31'd0, Done}, 32'd0);
    tick();
    check("drain_done_held", {31'd0, Done}, 32'd0);
    pop_check("drain_add", 32'h00221820);
    waited = 0;
    while (!Done && waited < 20) begin
      tick();
      waited++;
    end
    check("done_pulse", {31'd0, Done}, 32'd1);
    tick();
    check("done_once", {31'd0, Done}, 32'd0);
    check("done_error_sticky", {31'd0, Error}, 32'd1);
    check("done_idle_inready", {31'd0, InReady}, 32'd0);
    check("done_count", {16'd0, Count}, {16'd0, exp_count});

    // Start clears Error/Count and rewinds; Start beats Finish.
    pulse_start();
    check("restart_error", {31'd0, Error}, 32'd0);
    check("restart_count", {16'd0, Count}, 32'd0);
    check("restart_addr", MemAddress, BASE);
    Start = 1'b1; Finish = 1'b1;
    tick();
    Start = 1'b0; Finish = 1'b0;
    check("start_prio_load", {31'd0, InReady}, 32'd1);
    tick();
    check("start_prio_nodone", {31'd0, Done}, 32'd0);

    // Branch word, plus its delay-slot NOP when enabled.
    pulse_start();
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    pop_ctrl("beq", 32'h1022FFFF);
    check("beq_count", {16'd0, Count}, {16'd0, exp_count});
    check("beq_drained", {31'd0, MemWrite}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encoder counterpart to the control decoder. It accepts symbolic instruction requests (op select plus fields), packs them into 32-bit MIPS words, and buffers them in a small FIFO.
- It then streams the words sequentially into instruction memory through a write handshake.
- It sits between the test/boot sequencer and instruction memory, so programs can be loaded without a pre-built memory image.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- BASE_ADDR, 32'h0, first instruction memory byte address after Start

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous active-high reset
- Start  in  1  pulse: rewind address to BASE_ADDR, clear Error/Done
- Finish  in  1  pulse: drain FIFO, then pulse Done
- InValid  in  1  request valid
- InReady  out  1  encoder can accept this cycle
- OpSel  in  5  instruction code (package enum)
- Rs, Rt, Rd, Shamt  in  5 each  register/shift fields
- Imm  in  16  immediate/branch offset
- Target  in  26  jump target
- MemWrite  out  1  write strobe to instruction memory
- MemReady  in  1  memory accepts write this cycle
- MemAddress  out  32  byte address (word aligned)
- MemWriteData  out  32  encoded word
- Error  out  1  sticky: illegal OpSel seen
- Done  out  1  one-cycle pulse after Finish drain
- Count  out  16  words written since Start

Behaviour:
- Reset: InReady=0, MemWrite=0, MemAddress=BASE_ADDR, MemWriteData=0, Error=0, Done=0, Count=0, FIFO empty, state IDLE.
- FSM states:
  - IDLE: only Start is honoured; Start -> LOAD.
  - LOAD: accept requests; Finish -> DRAIN.
  - DRAIN: InReady=0; when FIFO empty and no write pending -> DONE.
  - DONE: Done=1 for one cycle -> IDLE.
  - Start in any state (including mid-DRAIN) flushes the FIFO, rewinds the address, clears Count/Error and goes to LOAD. Start takes priority over Finish when both are asserted in the same cycle.
- Handshake in: InReady = (state==LOAD) && FIFO not full. A transfer occurs on InValid && InReady. The encoded word enters the FIFO at the next edge (1-cycle latency).
- Encoding (opcode/funct):
  - R-type op 000000, word = {op,Rs,Rt,Rd,Shamt,funct}: ADD 100000, SUB 100010, AND 100100, OR 100101, SLL 000000, SRL 000010, JR 001000 (Rt,Rd,Shamt forced 0).
  - MUL: op 011100, funct 000010.
  - I-type, word = {op,Rs,Rt,Imm}: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LW 100011, SW 101011, LB 100000, LH 100001, SB 101000, SH 101001, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111.
  - BGEZ: op 000001, Rt field forced 00001. BLTZ: op 000001, Rt field forced 00000. BLEZ and BGTZ force Rt to 0.
  - J-type, word = {op,Target}: J 000010, JAL 000011.
  - Unused input fields are zeroed in the word.
- Illegal OpSel (outside the enum): the request is still accepted (handshake completes), no FIFO write, Error is set sticky.
- Output side: MemWrite=1 whenever the FIFO is non-empty; MemWriteData = FIFO head. On MemWrite && MemReady: pop, MemAddress += 4, Count += 1.
- MemAddress wraps modulo 2^32; Count saturates at 16'hFFFF.
- Simultaneous push and pop when the FIFO is full is not possible (InReady=0). Push and pop in the same cycle when the FIFO is partially full is allowed; occupancy is unchanged.

Optional Feature:
- DELAY_SLOT_NOP_EN defined: after every branch/jump/JR/JAL word, the encoder enqueues an extra 32'h0 (sll $0,$0,0).
  - Needs 2 free entries to accept such a request; InReady is deasserted otherwise.
  - Count includes the NOPs.
- DELAY_SLOT_NOP_EN undefined: no insertion; one word per request.

Decomposition:
- Shared package (isa_pkg): OpSel enum, opcode/funct localparams, the DONE/LOAD/DRAIN/IDLE state encoding, and an encode function returning {legal, word}.
- Sub-module: sync_fifo (DEPTH, width 32), with push/pop/full/empty/count outputs.

Test Plan:
- Reset with Rst high mid-LOAD, FIFO holding 3 words -> all outputs at reset values, FIFO empty, MemAddress=BASE_ADDR.
- Start; ADD Rs=1 Rt=2 Rd=3 -> MemWriteData=32'h00221820 at address 0. ADDI Rs=0 Rt=8 Imm=5 -> 32'h20080005 at 4. Count=2.
- BGEZ Rs=4 Imm=3 -> 32'h04810003. BLTZ Rs=4 Imm=3 -> 32'h04800003. JAL Target=26'h10 -> 32'h0C000010.
- Hold MemReady=0 and push DEPTH words -> InReady drops. Release -> words written in order, addresses 0..4*(DEPTH-1).
- OpSel=31 (illegal) -> Error=1, no MemWrite, Count unchanged. Finish -> Done pulses once after the FIFO empties. Start -> Error=0.
- With DELAY_SLOT_NOP_EN: BEQ Rs=1 Rt=2 Imm=-1 -> 32'h1022FFFF then 32'h00000000, Count=2.
